fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch for the MIPS front end. Owns the PC register and
//  drives a req/ack instruction-memory port. Applies branch/jump redirects and
//  presents one fetched instruction at a time to decode under a stall handshake.
//  Sits between the PC/adder/instruction-memory datapath and the IF/ID register.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  imem_req       out  1   fetch request; held with stable addr until imem_ack
//  imem_addr      out  32  fetch address, word aligned ([1:0]=0)
//  imem_ack       in   1   read data valid; sampled only while imem_req=1
//  imem_rdata     in   32  instruction word, valid when imem_ack=1
//  id_stall       in   1   decode cannot accept; slot held while 1
//  branch_taken   in   1   redirect to branch_target this cycle
//  branch_target  in   32  branch address; [1:0] ignored (forced 0)
//  jump           in   1   redirect to jump_target this cycle
//  jump_target    in   32  jump address; [1:0] ignored (forced 0)
//  if_valid       out  1   if_inst/if_pc hold a valid fetched instruction
//  if_inst        out  32  fetched instruction
//  if_pc          out  32  address of if_inst
//  if_pc_plus4    out  32  if_pc + 4, modulo 2^32
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, state=IDLE, outstanding=0, if_valid=0,
//    if_inst=0, if_pc=0. imem_req=0 while in reset and in IDLE.
//  - States: IDLE -> FETCH (unconditional, 1st clk after rst release);
//    FETCH -> KILL on redirect while a request is pending and not acked that cycle;
//    KILL -> FETCH on imem_ack.
//  - outstanding: set when imem_req=1 and imem_ack=0; cleared on imem_ack.
//  - FETCH: imem_req = outstanding | !if_valid | !id_stall; imem_addr=pc.
//    Once raised, imem_req stays high with stable addr until ack (no retraction).
//  - Slot consumed at posedge when if_valid=1 and id_stall=0.
//  - Ack in FETCH, no redirect: next cycle if_inst=imem_rdata, if_pc=pc,
//    if_valid=1; pc<=pc+4 (wraps 0xFFFF_FFFC -> 0). Zero-wait memory (ack in
//    request cycle) and no stall give 1 instr/cycle, first if_valid 2 clks after rst.
//  - Consumed with no ack same cycle: if_valid<=0.
//  - Ack can only load an empty or just-consumed slot (one request outstanding max).
//  - Redirect = branch_taken | jump; target = branch_target if branch_taken,
//    else jump_target (branch wins if both). Target [1:0] forced to 0.
//    On redirect, any state: if_valid<=0 (flush, overrides stall), pc<=target.
//  - Redirect with ack same cycle: rdata discarded, stay FETCH, next req at target.
//  - Redirect with pending unacked req: enter KILL; req/addr held at old pc until
//    ack; rdata discarded; no if_valid. Then FETCH requests at target.
//  - Redirect during KILL: pc<=new target (latest wins), remain in KILL.
//  - id_stall ignored while if_valid=0.
//  - rst mid-request: request dropped, all state to reset values; stale ack ignored
//    (imem_req=0).
// TESTING
//  1 rst 3 clks, release, ack=imem_req (0-wait) -> imem_addr 0x0 first req; if_pc 0,4,8,C on consecutive clks.
//  2 id_stall=1 for 3 clks while if_valid, if_pc=0x8 -> if_pc/if_inst held, no new req
//    starts; stall=0 -> 0xC next.
//  3 3-cycle-ack memory, jump=1 target 0x40 while req at 0x10 pending -> 0x10 held
//    to ack, data dropped, if_valid=0, next req 0x40, if_pc=0x40.
//  4 branch_taken=1 (0x100) & jump=1 (0x200) same clk -> next req 0x100; target 0x103
//    -> req addr 0x100.
//  5 RESET_PC=32'hFFFF_FFFC, 0-wait -> if_pc FFFF_FFFC, if_pc_plus4 0, next if_pc 0.
//  6 rst pulse mid 3-cycle request -> imem_req=0 immediately; refetch RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives a req/ack instruction-memory
// port, applies branch/jump redirects and holds one fetched instruction for decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_KILL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic        outstanding_q, outstanding_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_pc_q, if_pc_d;

  logic        redirect;
  logic [31:0] target;
  logic        req;
  logic [31:0] addr;
  logic        accept;
  logic        consume;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  always_comb begin
    redirect = branch_taken | jump;
    target   = word_align(branch_taken ? branch_target : jump_target);
    consume  = if_valid_q & ~id_stall;

    req  = 1'b0;
    addr = pc_q;
    case (state_q)
      ST_FETCH: req = outstanding_q | ~if_valid_q | ~id_stall;
      // The abandoned request must complete at its original address.
      ST_KILL: begin
        req  = 1'b1;
        addr = kill_addr_q;
      end
      default: req = 1'b0;
    endcase

    accept = (state_q == ST_FETCH) & req & imem_ack & ~redirect;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_addr_d   = kill_addr_q;
    outstanding_d = req & ~imem_ack;
    if_valid_d    = if_valid_q;
    if_inst_d     = if_inst_q;
    if_pc_d       = if_pc_q;

    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (redirect && req && !imem_ack) begin
          state_d     = ST_KILL;
          kill_addr_d = pc_q;
        end
      end
      ST_KILL:  if (imem_ack) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase

    // Flush beats stall; an ack only ever lands in an empty or just-consumed slot.
    if (redirect) begin
      if_valid_d = 1'b0;
      pc_d       = target;
    end else if (accept) begin
      if_valid_d = 1'b1;
      if_inst_d  = imem_rdata;
      if_pc_d    = pc_q;
      pc_d       = pc_q + 32'd4;
    end else if (consume) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      kill_addr_q   <= RESET_PC;
      outstanding_q <= 1'b0;
      if_valid_q    <= 1'b0;
      if_inst_q     <= 32'd0;
      if_pc_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_addr_q   <= kill_addr_d;
      outstanding_q <= outstanding_d;
      if_valid_q    <= if_valid_d;
      if_inst_q     <= if_inst_d;
      if_pc_q       <= if_pc_d;
    end
  end

  assign imem_req    = req;
  assign imem_addr   = addr;
  assign if_valid    = if_valid_q;
  assign if_inst     = if_inst_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: zero-wait and 3-cycle memory, stall,
// redirects (incl. during a pending request), PC wrap and mid-request reset.
module tb_fetch_sequencer;

  localparam logic [31:0] KEY = 32'h8C00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  logic        rst2;
  logic        req2;
  logic [31:0] addr2;
  logic        valid2;
  logic [31:0] inst2;
  logic [31:0] pc2;
  logic [31:0] p4_2;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'd0;

  int lat;
  int wait_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: ack in the lat-th cycle of a request; data is a function of address.
  assign imem_ack   = imem_req && (wait_cnt >= lat - 1);
  assign imem_rdata = imem_addr ^ KEY;

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  fetch_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_stall(id_stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(req2), .imem_rdata(addr2 ^ KEY),
    .id_stall(zero1),
    .branch_taken(zero1), .branch_target(zero32),
    .jump(zero1), .jump_target(zero32),
    .if_valid(valid2), .if_inst(inst2),
    .if_pc(pc2), .if_pc_plus4(p4_2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_valid); end
    checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL rst_pc got %h exp 0", if_pc); end
    checks++; if (if_inst !== 32'd0) begin errors++; $display("FAIL rst_inst got %h exp 0", if_inst); end
    rst = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", imem_req); end
  endtask

  task automatic test_stream();
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_inst !== (32'(i * 4) ^ KEY)) begin
        errors++; $display("FAIL stream_%0d got v=%b pc=%h inst=%h exp pc=%h", i, if_valid, if_pc, if_inst, 32'(i * 4)); end
    end
    checks++; if (if_pc_plus4 !== 32'hC) begin errors++; $display("FAIL stream_p4 got %h exp c", if_pc_plus4); end
  endtask

  task automatic test_stall();
    id_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_%0d got %b exp 0", i, imem_req); end
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== (32'h8 ^ KEY)) begin
        errors++; $display("FAIL stall_hold_%0d got v=%b pc=%h inst=%h exp pc=8", i, if_valid, if_pc, if_inst); end
    end
    id_stall = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      errors++; $display("FAIL unstall_req got req=%b addr=%h exp 1/c", imem_req, imem_addr); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hC) begin
      errors++; $display("FAIL unstall_pc got v=%b pc=%h exp c", if_valid, if_pc); end
  endtask

  task automatic test_kill();
    int n;
    lat = 3;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || imem_ack !== 1'b0) begin
      errors++; $display("FAIL kill_req got req=%b addr=%h ack=%b exp 1/10/0", imem_req, imem_addr, imem_ack); end
    step();
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL kill_pend got v=%b addr=%h exp 0/10", if_valid, imem_addr); end
    jump = 1'b1; jump_target = 32'h40;
    step();
    jump = 1'b0; jump_target = 32'h0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || imem_ack !== 1'b1) begin
      errors++; $display("FAIL kill_hold got req=%b addr=%h ack=%b exp 1/10/1", imem_req, imem_addr, imem_ack); end
    step();
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL kill_retarget got v=%b req=%b addr=%h exp 0/1/40", if_valid, imem_req, imem_addr); end
    n = 0;
    while (if_valid !== 1'b1 && n < 10) begin step(); n++; end
    checks++; if (n !== 3 || if_pc !== 32'h40 || if_inst !== (32'h40 ^ KEY)) begin
      errors++; $display("FAIL kill_land got cycles=%0d pc=%h inst=%h exp 3/40", n, if_pc, if_inst); end
  endtask

  task automatic test_redirect_prio();
    lat = 1;
    branch_taken = 1'b1; branch_target = 32'h100;
    jump = 1'b1; jump_target = 32'h200;
    step();
    branch_taken = 1'b0; jump = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL prio_req got v=%b req=%b addr=%h exp 0/1/100", if_valid, imem_req, imem_addr); end
    branch_taken = 1'b1; branch_target = 32'h103;
    step();
    branch_taken = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL align_req got v=%b addr=%h exp 0/100", if_valid, imem_addr); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== (32'h100 ^ KEY)) begin
      errors++; $display("FAIL align_land got v=%b pc=%h inst=%h exp 100", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_wrap();
    step();
    rst2 = 1'b0;
    step();
    checks++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_req got req=%b addr=%h exp 1/fffffffc", req2, addr2); end
    step();
    checks++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || p4_2 !== 32'h0 || inst2 !== (32'hFFFF_FFFC ^ KEY)) begin
      errors++; $display("FAIL wrap_top got v=%b pc=%h p4=%h inst=%h exp fffffffc/0", valid2, pc2, p4_2, inst2); end
    step();
    checks++; if (valid2 !== 1'b1 || pc2 !== 32'h0 || p4_2 !== 32'h4) begin
      errors++; $display("FAIL wrap_zero got v=%b pc=%h p4=%h exp 0/4", valid2, pc2, p4_2); end
  endtask

  task automatic test_mid_reset();
    int n;
    lat = 3;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || imem_ack !== 1'b0) begin
      errors++; $display("FAIL mr_pend got req=%b addr=%h ack=%b exp 1/0/0", imem_req, imem_addr, imem_ack); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0) begin
      errors++; $display("FAIL mr_drop got req=%b v=%b pc=%h exp 0/0/0", imem_req, if_valid, if_pc); end
    step();
    rst = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL mr_refetch got req=%b addr=%h exp 1/0", imem_req, imem_addr); end
    n = 0;
    while (if_valid !== 1'b1 && n < 10) begin step(); n++; end
    checks++; if (n !== 3 || if_pc !== 32'h0 || if_inst !== KEY) begin
      errors++; $display("FAIL mr_land got cycles=%0d pc=%h inst=%h exp 3/0", n, if_pc, if_inst); end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; lat = 1;
    id_stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_kill();
    test_redirect_prio();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
